// File: rtl/srl16_fifo.sv
// srl16_fifo: 16-deep WIDTH-bit FIFO built on an SRLC16E-style shift line
// (shift on write, read tap = cnt-1) followed by a registered output stage.
// Ports:
//   CLK, RST_N               clock, async active-low reset
//   S_VALID/S_READY/S_DATA   write side handshake and data
//   M_VALID/M_READY/M_DATA   read side handshake and registered data
//   LEVEL                    occupancy including the output register, 0..17
//   SRL_ADDR                 current read tap of the shift line
module srl16_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [4:0]       LEVEL,
  output logic [3:0]       SRL_ADDR
);

  logic [WIDTH-1:0] srl_q [16];

  logic [4:0]       cnt_q, cnt_d;
  logic             mv_q, mv_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic             rdy_q;

  logic             full, empty;
  logic             push, pop;
  logic [3:0]       addr;

  assign full  = (cnt_q == 5'd16);
  assign empty = (cnt_q == 5'd0);

  assign S_READY = rdy_q & ~full;
  assign push    = S_VALID & S_READY;
  assign pop     = ~empty & (~mv_q | M_READY);

  // At cnt=16 the low nibble is 0, so the subtraction wraps to tap 15.
  assign addr = empty ? 4'd0 : (cnt_q[3:0] - 4'd1);

  assign SRL_ADDR = addr;
  assign M_VALID  = mv_q;
  assign M_DATA   = md_q;
  assign LEVEL    = cnt_q + {4'd0, mv_q};

  // The line mirrors the primitive: no reset, shift only on push.
  always_ff @(posedge CLK) begin
    if (push) begin
      srl_q[0] <= S_DATA;
      for (int i = 1; i < 16; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + {4'd0, push} - {4'd0, pop};
    mv_d  = mv_q;
    md_d  = md_q;
    if (pop) begin
      mv_d = 1'b1;
      md_d = srl_q[addr];
    end else if (M_READY) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= 5'd0;
      mv_q  <= 1'b0;
      md_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mv_q  <= mv_d;
      md_q  <= md_d;
      rdy_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_srl16_fifo.sv
// tb_srl16_fifo: scoreboard bench for srl16_fifo.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_srl16_fifo;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         S_VALID;
  logic         S_READY;
  logic [W-1:0] S_DATA;
  logic         M_VALID;
  logic         M_READY;
  logic [W-1:0] M_DATA;
  logic [4:0]   LEVEL;
  logic [3:0]   SRL_ADDR;

  srl16_fifo #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .S_DATA   (S_DATA),
    .M_VALID  (M_VALID),
    .M_READY  (M_READY),
    .M_DATA   (M_DATA),
    .LEVEL    (LEVEL),
    .SRL_ADDR (SRL_ADDR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int           vectors;
  int           miscompares;
  int           pushed;
  int           taken;
  logic [W-1:0] exp_q [$];

  // Called at a falling edge with inputs set: records the handshakes that
  // the next rising edge will perform, then returns at the following
  // falling edge.
  task automatic step();
    logic [W-1:0] e;
    vectors++;
    if (LEVEL !== 5'(pushed - taken)) begin
      miscompares++;
      $display("FAIL level: got %0d want %0d", LEVEL, pushed - taken);
    end
    if (S_VALID && S_READY) begin
      exp_q.push_back(S_DATA);
      pushed++;
    end
    if (M_VALID && M_READY) begin
      vectors++;
      taken++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: got %02h want none", M_DATA);
      end else begin
        e = exp_q.pop_front();
        if (M_DATA !== e) begin
          miscompares++;
          $display("FAIL sb_data: got %02h want %02h", M_DATA, e);
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    S_VALID = 1'b0;
    M_READY = 1'b1;
    while ((M_VALID || LEVEL != 0) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (M_VALID || LEVEL != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: level %0d q %0d want 0 0", LEVEL, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RST_N   = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 8'h55;
    M_READY = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({S_READY, M_VALID, LEVEL, M_DATA} !== '0) begin
      miscompares++;
      $display("FAIL reset_out: rdy %b mv %b lvl %0d d %02h want 0",
               S_READY, M_VALID, LEVEL, M_DATA);
    end
    RST_N   = 1'b1;
    S_VALID = 1'b0;
    #1;
    vectors++;
    if (S_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL rdy_pre: got %b want 0", S_READY);
    end
    @(negedge CLK);
    step();
    vectors++;
    if (S_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL rdy_post: got %b want 1", S_READY);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] ev [3];
    int           lv [3];
    ev = '{8'h00, 8'h01, 8'h00};
    lv = '{1, 1, 0};
    S_VALID = 1'b1;
    S_DATA  = 8'hA5;
    M_READY = 1'b1;
    step();
    S_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (M_VALID !== ev[i][0] || LEVEL !== 5'(lv[i])) begin
        miscompares++;
        $display("FAIL single_%0d: mv %b lvl %0d want %b %0d",
                 i, M_VALID, LEVEL, ev[i][0], lv[i]);
      end
      if (i == 1) begin
        vectors++;
        if (M_DATA !== 8'hA5) begin
          miscompares++;
          $display("FAIL single_data: got %02h want a5", M_DATA);
        end
      end
      if (i < 2) step();
    end
  endtask

  task automatic test_fill();
    int p0;
    p0 = pushed;
    M_READY = 1'b0;
    for (int d = 0; d < 20; d++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(d);
      step();
    end
    S_VALID = 1'b0;
    vectors++;
    if (pushed - p0 != 17) begin
      miscompares++;
      $display("FAIL fill_count: got %0d want 17", pushed - p0);
    end
    vectors++;
    if (S_READY !== 1'b0 || LEVEL !== 5'd17 || SRL_ADDR !== 4'd15) begin
      miscompares++;
      $display("FAIL fill_full: rdy %b lvl %0d addr %0d want 0 17 15",
               S_READY, LEVEL, SRL_ADDR);
    end
    M_READY = 1'b1;
    step();
    vectors++;
    if (S_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_rdy: got %b want 1", S_READY);
    end
    drain(40);
  endtask

  task automatic test_back_to_back();
    M_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(i + 1);
      step();
      if (i >= 1) begin
        vectors++;
        if (M_VALID !== 1'b1 || LEVEL !== 5'd2) begin
          miscompares++;
          $display("FAIL stream_%0d: mv %b lvl %0d want 1 2",
                   i, M_VALID, LEVEL);
        end
      end
    end
    drain(10);
  endtask

  task automatic test_random();
    int pct [3];
    pct = '{50, 15, 85};
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < (ph == 0 ? 10000 : 2000); c++) begin
        S_VALID = ($urandom_range(99) < 50);
        S_DATA  = 8'($urandom);
        M_READY = ($urandom_range(99) < pct[ph]);
        step();
      end
    end
    drain(40);
  endtask

  task automatic test_mid_reset();
    M_READY = 1'b0;
    for (int i = 0; i < 9; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(8'hC0 + i);
      step();
    end
    S_VALID = 1'b0;
    vectors++;
    if (LEVEL !== 5'd9) begin
      miscompares++;
      $display("FAIL pre_reset_lvl: got %0d want 9", LEVEL);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if ({S_READY, M_VALID, M_DATA, LEVEL, SRL_ADDR} !== '0) begin
      miscompares++;
      $display("FAIL async_rst: rdy %b mv %b d %02h lvl %0d a %0d want 0",
               S_READY, M_VALID, M_DATA, LEVEL, SRL_ADDR);
    end
    exp_q.delete();
    pushed = 0;
    taken  = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    S_VALID = 1'b1;
    S_DATA  = 8'h3C;
    M_READY = 1'b0;
    step();
    S_VALID = 1'b0;
    step();
    vectors++;
    if (M_VALID !== 1'b1 || M_DATA !== 8'h3C) begin
      miscompares++;
      $display("FAIL post_rst_data: mv %b d %02h want 1 3c", M_VALID, M_DATA);
    end
    drain(10);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pushed      = 0;
    taken       = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
